wasca_sdram_arbiter: RTL and testbench

// - Shares the single SDRAM controller Avalon-MM slave between two requesters:

---
 rtl/wasca_arb_pkg.sv | 13 +
 rtl/wasca_tag_fifo.sv | 69 ++++++
 rtl/wasca_sdram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_wasca_sdram_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wasca_arb_pkg.sv
// Shared types and defaults for the wasca SDRAM arbiter.
// Optional starvation guard is enabled by defining WASCA_ARB_STARVE_GUARD_EN.
package wasca_arb_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_C = 1'b1
    } port_id_t;

    localparam int unsigned MAX_PEND_DEF     = 4;
    localparam int unsigned STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/wasca_tag_fifo.sv
// Synchronous FIFO of port ids recording which requester issued each outstanding read.
// A push while full is accepted only when a pop happens in the same cycle.
module wasca_tag_fifo
    import wasca_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_PEND_DEF
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  port_id_t tag_i,
    input  logic     pop_i,
    output port_id_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    port_id_t         mem_q [DEPTH];
    port_id_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & (~full_o | pop_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = tag_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= PORT_A;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wasca_sdram_arbiter.sv
// Two-port Avalon-MM arbiter in front of the SDRAM controller: port A has fixed priority,
// read data is steered back by tag. WASCA_ARB_STARVE_GUARD_EN adds a forced grant for port C.
module wasca_sdram_arbiter
    import wasca_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 25,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_PEND = MAX_PEND_DEF
`ifdef WASCA_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,

    input  logic [ADDR_W-1:0]   a_address,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [DATA_W-1:0]   a_writedata,
    input  logic [DATA_W/8-1:0] a_byteenable,
    output logic                a_waitrequest,
    output logic [DATA_W-1:0]   a_readdata,
    output logic                a_readdatavalid,

    input  logic [ADDR_W-1:0]   c_address,
    input  logic                c_read,
    input  logic                c_write,
    input  logic [DATA_W-1:0]   c_writedata,
    input  logic [DATA_W/8-1:0] c_byteenable,
    output logic                c_waitrequest,
    output logic [DATA_W-1:0]   c_readdata,
    output logic                c_readdatavalid,

    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,

    output logic                err_orphan
);

    port_id_t    owner_q, owner_d;
    port_id_t    head;
    logic        ready_q;
    logic        a_req, c_req, own_read, own_write;
    logic        fifo_full, fifo_empty, rd_block, stalled;
    logic        push, pop, c_accept;
    logic        force_grant, hold_c;
    logic        err_q, err_d;
    logic        a_rdv_q, a_rdv_d, c_rdv_q, c_rdv_d;
    logic [DATA_W-1:0] a_rd_q, a_rd_d, c_rd_q, c_rd_d;

    assign a_req     = a_read | a_write;
    assign c_req     = c_read | c_write;
    assign own_read  = (owner_q == PORT_A) ? a_read : c_read;
    assign own_write = (owner_q == PORT_A) ? a_write : c_write;

    // A return in the same cycle frees a slot, so a read at full may proceed.
    assign rd_block = fifo_full & ~m_readdatavalid;

    assign m_address    = (owner_q == PORT_A) ? a_address : c_address;
    assign m_writedata  = (owner_q == PORT_A) ? a_writedata : c_writedata;
    assign m_byteenable = (owner_q == PORT_A) ? a_byteenable : c_byteenable;
    assign m_read       = ready_q & own_read & ~rd_block;
    assign m_write      = ready_q & own_write;

    assign a_waitrequest = ~ready_q | (owner_q != PORT_A) | m_waitrequest | (a_read & rd_block);
    assign c_waitrequest = ~ready_q | (owner_q != PORT_C) | m_waitrequest | (c_read & rd_block);

    assign stalled  = (m_read | m_write) & m_waitrequest;
    assign push     = m_read & ~m_waitrequest;
    assign pop      = m_readdatavalid & ~fifo_empty;
    assign c_accept = (owner_q == PORT_C) & (m_read | m_write) & ~m_waitrequest;

`ifdef WASCA_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             forced_q, forced_d;

    assign force_grant = (starve_q == CNT_W'(STARVE_LIMIT)) & c_req & (owner_q != PORT_C);
    // Keep a forced grant until C actually lands one command.
    assign hold_c      = forced_q & (owner_q == PORT_C) & c_req & ~c_accept;

    always_comb begin
        starve_d = starve_q;
        if (owner_q == PORT_C) begin
            starve_d = '0;
        end else if (c_req && (starve_q != CNT_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
        forced_d = forced_q & (owner_d == PORT_C) & ~c_accept;
        if (!stalled && force_grant) begin
            forced_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            starve_q <= '0;
            forced_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            forced_q <= forced_d;
        end
    end
`else
    assign force_grant = 1'b0;
    assign hold_c      = 1'b0;
`endif

    always_comb begin
        owner_d = owner_q;
        if (!stalled) begin
            if (hold_c || force_grant) begin
                owner_d = PORT_C;
            end else if (a_req) begin
                owner_d = PORT_A;
            end else if (c_req) begin
                owner_d = PORT_C;
            end
        end
    end

    always_comb begin
        err_d   = err_q | (m_readdatavalid & fifo_empty);
        a_rd_d  = a_rd_q;
        c_rd_d  = c_rd_q;
        a_rdv_d = 1'b0;
        c_rdv_d = 1'b0;
        if (pop) begin
            if (head == PORT_A) begin
                a_rd_d  = m_readdata;
                a_rdv_d = 1'b1;
            end else begin
                c_rd_d  = m_readdata;
                c_rdv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            owner_q <= PORT_A;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            a_rd_q  <= '0;
            c_rd_q  <= '0;
            a_rdv_q <= 1'b0;
            c_rdv_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            ready_q <= 1'b1;
            err_q   <= err_d;
            a_rd_q  <= a_rd_d;
            c_rd_q  <= c_rd_d;
            a_rdv_q <= a_rdv_d;
            c_rdv_q <= c_rdv_d;
        end
    end

    assign a_readdata      = a_rd_q;
    assign a_readdatavalid = a_rdv_q;
    assign c_readdata      = c_rd_q;
    assign c_readdatavalid = c_rdv_q;
    assign err_orphan      = err_q;

    wasca_tag_fifo #(
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .push_i  (push),
        .tag_i   (owner_q),
        .pop_i   (m_readdatavalid),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_wasca_sdram_arbiter.sv
// Directed bench for wasca_sdram_arbiter; checks the guard scenario matching the build
// (WASCA_ARB_STARVE_GUARD_EN defined or not).
module tb_wasca_sdram_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [24:0] a_address = '0, c_address = '0, m_address;
    logic        a_read = 1'b0, a_write = 1'b0, c_read = 1'b0, c_write = 1'b0;
    logic [15:0] a_writedata = '0, c_writedata = '0, m_writedata;
    logic [1:0]  a_byteenable = '0, c_byteenable = '0, m_byteenable;
    logic        a_waitrequest, c_waitrequest, a_readdatavalid, c_readdatavalid;
    logic [15:0] a_readdata, c_readdata;
    logic        m_read, m_write;
    logic        m_waitrequest = 1'b0;
    logic [15:0] m_readdata = '0;
    logic        m_readdatavalid = 1'b0;
    logic        err_orphan;

    int checks = 0;
    int errors = 0;

    always #5 clk_clk = ~clk_clk;

    wasca_sdram_arbiter dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .a_address       (a_address),
        .a_read          (a_read),
        .a_write         (a_write),
        .a_writedata     (a_writedata),
        .a_byteenable    (a_byteenable),
        .a_waitrequest   (a_waitrequest),
        .a_readdata      (a_readdata),
        .a_readdatavalid (a_readdatavalid),
        .c_address       (c_address),
        .c_read          (c_read),
        .c_write         (c_write),
        .c_writedata     (c_writedata),
        .c_byteenable    (c_byteenable),
        .c_waitrequest   (c_waitrequest),
        .c_readdata      (c_readdata),
        .c_readdatavalid (c_readdatavalid),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .err_orphan      (err_orphan)
    );

    task automatic next_cycle();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_read = 1'b0; a_write = 1'b0; c_read = 1'b0; c_write = 1'b0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_reset_n = 1'b0;
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_reset_n = 1'b0;
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        checks++; if (a_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_a_wait: got %b want 1", a_waitrequest); end
        checks++; if (c_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_c_wait: got %b want 1", c_waitrequest); end
        checks++; if ({m_read, m_write} !== 2'b00) begin errors++; $display("FAIL reset_m_cmd: got %b want 00", {m_read, m_write}); end
        checks++; if ({a_readdatavalid, c_readdatavalid} !== 2'b00) begin errors++; $display("FAIL reset_rdv: got %b want 00", {a_readdatavalid, c_readdatavalid}); end
        checks++; if ({a_readdata, c_readdata} !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h want 0", {a_readdata, c_readdata}); end
        reset_reset_n = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk_clk);
        checks++; if ({m_read, m_write} !== 2'b00) begin errors++; $display("FAIL idle_m_cmd: got %b want 00", {m_read, m_write}); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL idle_err: got %b want 0", err_orphan); end
        checks++; if (a_waitrequest !== 1'b0) begin errors++; $display("FAIL idle_a_wait: got %b want 0", a_waitrequest); end
        next_cycle();
    endtask

    task automatic test_both_read();
        a_read = 1'b1; a_address = 25'h100;
        c_read = 1'b1; c_address = 25'h200;
        @(negedge clk_clk);
        checks++; if ({a_waitrequest, c_waitrequest} !== 2'b01) begin errors++; $display("FAIL both_grant_a: got %b want 01", {a_waitrequest, c_waitrequest}); end
        checks++; if (m_read !== 1'b1 || m_address !== 25'h100) begin errors++; $display("FAIL both_m_a: got %b/%h want 1/100", m_read, m_address); end
        next_cycle();
        a_read = 1'b0;
        @(negedge clk_clk);
        checks++; if (c_waitrequest !== 1'b1) begin errors++; $display("FAIL both_c_wait: got %b want 1", c_waitrequest); end
        next_cycle();
        @(negedge clk_clk);
        checks++; if (c_waitrequest !== 1'b0 || m_address !== 25'h200) begin errors++; $display("FAIL both_grant_c: got %b/%h want 0/200", c_waitrequest, m_address); end
        next_cycle();
        c_read = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 16'h1234;
        @(negedge clk_clk);
        checks++; if (a_readdatavalid !== 1'b0) begin errors++; $display("FAIL both_latency: got %b want 0", a_readdatavalid); end
        next_cycle();
        m_readdata = 16'h5678;
        @(negedge clk_clk);
        checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== 16'h1234 || c_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL both_ret_a: got %b/%h/%b want 1/1234/0", a_readdatavalid, a_readdata, c_readdatavalid); end
        next_cycle();
        m_readdatavalid = 1'b0;
        @(negedge clk_clk);
        checks++; if (c_readdatavalid !== 1'b1 || c_readdata !== 16'h5678 || a_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL both_ret_c: got %b/%h/%b want 1/5678/0", c_readdatavalid, c_readdata, a_readdatavalid); end
        next_cycle();
    endtask

    // Owner is C here; a stalled C write must keep ownership even with A pending.
    task automatic test_stall();
        c_write = 1'b1; c_writedata = 16'hC0DE; c_byteenable = 2'b01;
        a_write = 1'b1; a_writedata = 16'hA0A0; a_byteenable = 2'b10;
        m_waitrequest = 1'b1;
        @(negedge clk_clk);
        checks++; if ({a_waitrequest, c_waitrequest, m_write} !== 3'b111 || m_writedata !== 16'hC0DE) begin
            errors++; $display("FAIL stall_c_issue: got %b/%h want 111/c0de", {a_waitrequest, c_waitrequest, m_write}, m_writedata); end
        next_cycle();
        @(negedge clk_clk);
        checks++; if (m_writedata !== 16'hC0DE || m_byteenable !== 2'b01 || a_waitrequest !== 1'b1) begin
            errors++; $display("FAIL stall_hold: got %h/%b/%b want c0de/01/1", m_writedata, m_byteenable, a_waitrequest); end
        next_cycle();
        m_waitrequest = 1'b0;
        @(negedge clk_clk);
        checks++; if (c_waitrequest !== 1'b0 || m_write !== 1'b1) begin errors++; $display("FAIL stall_release: got %b/%b want 0/1", c_waitrequest, m_write); end
        next_cycle();
        c_write = 1'b0;
        @(negedge clk_clk);
        checks++; if (a_waitrequest !== 1'b0 || m_writedata !== 16'hA0A0 || m_byteenable !== 2'b10) begin
            errors++; $display("FAIL stall_to_a: got %b/%h/%b want 0/a0a0/10", a_waitrequest, m_writedata, m_byteenable); end
        next_cycle();
        a_write = 1'b0;
    endtask

    task automatic test_fifo_full();
        c_read = 1'b1; c_address = 25'h300;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_clk);
            checks++; if (c_waitrequest !== 1'b0 || m_read !== 1'b1) begin errors++; $display("FAIL full_accept%0d: got %b/%b want 0/1", i, c_waitrequest, m_read); end
            next_cycle();
        end
        @(negedge clk_clk);
        checks++; if (c_waitrequest !== 1'b1 || m_read !== 1'b0) begin errors++; $display("FAIL full_block: got %b/%b want 1/0", c_waitrequest, m_read); end
        next_cycle();
        m_readdatavalid = 1'b1; m_readdata = 16'hAAAA;
        @(negedge clk_clk);
        checks++; if (c_waitrequest !== 1'b0 || m_read !== 1'b1) begin errors++; $display("FAIL full_unblock: got %b/%b want 0/1", c_waitrequest, m_read); end
        next_cycle();
        c_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_readdata = 16'hB000 + 16'(i);
            @(negedge clk_clk);
            checks++; if (c_readdatavalid !== 1'b1 || c_readdata !== ((i == 0) ? 16'hAAAA : 16'hB000 + 16'(i - 1))) begin
                errors++; $display("FAIL full_drain%0d: got %b/%h", i, c_readdatavalid, c_readdata); end
            next_cycle();
        end
        m_readdatavalid = 1'b0;
        @(negedge clk_clk);
        checks++; if (c_readdatavalid !== 1'b1 || c_readdata !== 16'hB003) begin errors++; $display("FAIL full_drain_last: got %b/%h want 1/b003", c_readdatavalid, c_readdata); end
        next_cycle();
    endtask

    // Builds tags [A, C], then push C while popping A; the extra returns probe the count.
    task automatic test_push_pop_orphan();
        a_read = 1'b1;
        next_cycle();
        c_read = 1'b1;
        @(negedge clk_clk);
        checks++; if (a_waitrequest !== 1'b0) begin errors++; $display("FAIL pp_a_accept: got %b want 0", a_waitrequest); end
        next_cycle();
        a_read = 1'b0;
        next_cycle();
        @(negedge clk_clk);
        checks++; if (c_waitrequest !== 1'b0) begin errors++; $display("FAIL pp_c_accept: got %b want 0", c_waitrequest); end
        next_cycle();
        m_readdatavalid = 1'b1; m_readdata = 16'h1111;
        @(negedge clk_clk);
        checks++; if (c_waitrequest !== 1'b0 || m_read !== 1'b1) begin errors++; $display("FAIL pp_push_pop: got %b/%b want 0/1", c_waitrequest, m_read); end
        next_cycle();
        c_read = 1'b0; m_readdata = 16'h2222;
        @(negedge clk_clk);
        checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== 16'h1111 || c_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL pp_ret_a: got %b/%h/%b want 1/1111/0", a_readdatavalid, a_readdata, c_readdatavalid); end
        next_cycle();
        m_readdata = 16'h3333;
        @(negedge clk_clk);
        checks++; if (c_readdatavalid !== 1'b1 || c_readdata !== 16'h2222 || a_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL pp_ret_c1: got %b/%h/%b want 1/2222/0", c_readdatavalid, c_readdata, a_readdatavalid); end
        next_cycle();
        m_readdata = 16'hDEAD;
        @(negedge clk_clk);
        checks++; if (c_readdatavalid !== 1'b1 || c_readdata !== 16'h3333 || err_orphan !== 1'b0) begin
            errors++; $display("FAIL pp_ret_c2: got %b/%h/%b want 1/3333/0", c_readdatavalid, c_readdata, err_orphan); end
        next_cycle();
        m_readdatavalid = 1'b0;
        @(negedge clk_clk);
        checks++; if ({a_readdatavalid, c_readdatavalid} !== 2'b00 || err_orphan !== 1'b1) begin
            errors++; $display("FAIL orphan_set: got %b/%b want 00/1", {a_readdatavalid, c_readdatavalid}, err_orphan); end
        repeat (3) next_cycle();
        @(negedge clk_clk);
        checks++; if (err_orphan !== 1'b1 || c_readdata !== 16'h3333) begin errors++; $display("FAIL orphan_sticky: got %b/%h want 1/3333", err_orphan, c_readdata); end
        reset_reset_n = 1'b0;
        #1;
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_reset: got %b want 0", err_orphan); end
        next_cycle();
    endtask

    task automatic test_starve();
        do_reset();
        a_write = 1'b1; c_write = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_clk);
`ifdef WASCA_ARB_STARVE_GUARD_EN
            checks++; if ({a_waitrequest, c_waitrequest} !== ((k == 9) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL starve_guard_cyc%0d: got %b want %b", k, {a_waitrequest, c_waitrequest}, (k == 9) ? 2'b10 : 2'b01); end
`else
            checks++; if ({a_waitrequest, c_waitrequest} !== 2'b01) begin
                errors++; $display("FAIL starve_noguard_cyc%0d: got %b want 01", k, {a_waitrequest, c_waitrequest}); end
`endif
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_both_read();
        test_stall();
        test_fifo_full();
        test_push_pop_orphan();
        test_starve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
